tick_sched: RTL
===============

// Module: tick_sched
// PURPOSE
// - Single shared prescaler producing 1-cycle base_tick enables (no derived clocks) from clk.
// - Schedules NCH channels; each emits ch_tick[i] on every P_i-th base_tick.
// - Periods written through a valid/ready config port. A run/stop FSM starts and stops the timebase.
// - Consumers (display mux, debouncers, stopwatch counters) stay on clk and qualify logic with ticks.
// PARAMETERS
// - PRESCALE_DIV  100000  clk cycles per base_tick (1 ms at 100 MHz); legal range >=2, <2**PRESCALE_W
// - PRESCALE_W    20      prescaler counter width
// - NCH           4       number of scheduled channels
// - PER_W         16      channel period / counter width
// PORTS
// - clk         in   1          system clock; all logic on posedge
// - reset       in   1          synchronous, active-high; clears all state incl. period registers
// - run         in   1          level: 1 = timebase running, 0 = stopped
// - ch_en       in   NCH        per-channel enable (level)
// - cfg_we      in   1          config write valid
// - cfg_ch      in   $clog2(NCH) target channel
// - cfg_period  in   PER_W      period in base_ticks; 0 = channel disabled
// - cfg_ready   out  1          config write accepted this cycle when cfg_we & cfg_ready
// - busy        out  1          1 while FSM is in RUN
// - base_tick   out  1          1-cycle pulse per prescaler wrap
// - ch_tick     out  NCH        1-cycle pulse per channel period, coincident with base_tick
// BEHAVIOUR
// - Reset: state=IDLE; prescaler, all channel counters, all period regs = 0; busy=0, base_tick=0,
//   ch_tick=0, cfg_ready=1 (registered outputs take these values in the cycle after reset is sampled).
// - FSM IDLE: prescaler and channel counters held at 0, no ticks. Go to RUN when run=1 is sampled.
// - FSM RUN: the prescaler increments each cycle and wraps DIV-1 -> 0. Go to IDLE when run=0 is sampled.
//   On exit the prescaler and counters are cleared.
// - Latency: run first sampled 1 at cycle T -> first base_tick high at cycle T+PRESCALE_DIV+1.
//   Then base_tick repeats every PRESCALE_DIV cycles.
// - Wrap event W = (state==RUN && prescaler==DIV-1 && run==1). base_tick and ch_tick are registered
//   from W, so they are high in the cycle after W.
// - If run falls in the same cycle as the compare, W=0 and no tick is issued.
// - Channel i on W, with P=period[i] and c=counter[i]:
//   - if ch_en[i]=0 or P=0: c<=0 and no tick.
//   - else if c==P-1: ch_tick[i]<=1 and c<=0.
//   - else c<=c+1.
//   - P=1 ticks on every base_tick. Counters are PER_W bits unsigned; c never exceeds P-1.
// - ch_en[i] falling clears counter[i] on the next W (no partial-period carry on re-enable).
// - Config handshake:
//   - cfg_ready = !(state==RUN && prescaler==DIV-1), combinational. It is low only in the wrap cycle.
//   - Accept = cfg_we & cfg_ready. On accept: period[cfg_ch]<=cfg_period and counter[cfg_ch]<=0.
//   - The new period counts from the next W.
//   - cfg_we while cfg_ready=0 has no effect; the requester holds cfg_we/cfg_ch/cfg_period until accepted.
//   - cfg_ch >= NCH is accepted and ignored.
//   - Writes are accepted in IDLE and RUN.
// - busy = (state==RUN), registered.
// - Reset mid-run overrides everything, including an in-flight write and a pending tick.
// CONFIGURATION
// - TICK_SCHED_FAST_SIM_EN defined: effective divide = 4 regardless of PRESCALE_DIV (simulation
//   timebase). Prescaler width unchanged. All other behaviour identical.
// - Not defined: divide = PRESCALE_DIV.
// TESTING (bench compiled with TICK_SCHED_FAST_SIM_EN, divide=4, NCH=4)
// - Reset, write ch0 P=1, ch1 P=3, ch_en=4'b0011, run=1 at cycle T -> base_tick at T+5, T+9, T+13...;
//   ch_tick[0] on every base_tick; ch_tick[1] on the 3rd, 6th... base_tick.
// - cfg_we held across a wrap cycle -> cfg_ready=0 that cycle, write lands the next cycle;
//   period/counter updated exactly once.
// - Running ch1 P=3 after 2 base_ticks: rewrite P=2 -> next ch1 tick on the 2nd following base_tick.
// - Drop run the same cycle prescaler==3 -> no base_tick; busy=0 next cycle; re-run gives the
//   first tick DIV+1 cycles later, counters from 0.
// - ch_en[2]=1 with period[2]=0, and ch_en[3]=0 with P=1 -> ch_tick[3:2] never asserted.
// - Assert reset mid-run with ch0 P=1 -> all outputs 0; after release and run=1, no ch_tick
//   until periods are rewritten.

Source files
------------

// File: rtl/tick_sched.sv
// Shared prescaler timebase with NCH period-scheduled tick channels and a run/stop FSM.
// Define TICK_SCHED_FAST_SIM_EN to force an effective divide of 4 for simulation.
module tick_sched #(
    parameter  int PRESCALE_DIV = 100000,
    parameter  int PRESCALE_W   = 20,
    parameter  int NCH          = 4,
    parameter  int PER_W        = 16,
    localparam int CH_W         = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_run,
    input  logic [NCH-1:0]   i_ch_en,
    input  logic             i_cfg_we,
    input  logic [CH_W-1:0]  i_cfg_ch,
    input  logic [PER_W-1:0] i_cfg_period,
    output logic             o_cfg_ready,
    output logic             o_busy,
    output logic             o_base_tick,
    output logic [NCH-1:0]   o_ch_tick
);

`ifdef TICK_SCHED_FAST_SIM_EN
    localparam int EFF_DIV = 4;
`else
    localparam int EFF_DIV = PRESCALE_DIV;
`endif
    localparam logic [PRESCALE_W-1:0] DIV_M1 = PRESCALE_W'(EFF_DIV - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [PRESCALE_W-1:0] r_presc;
    logic [PER_W-1:0]     r_period [NCH];
    logic [PER_W-1:0]     r_count  [NCH];
    logic                 r_busy;
    logic                 r_base_tick;
    logic [NCH-1:0]       r_ch_tick;
    logic                 w_at_top;
    logic                 w_wrap;
    logic                 w_accept;

    // The wrap cycle blocks config writes so a write never races a channel update.
    assign w_at_top    = (r_state == ST_RUN) && (r_presc == DIV_M1);
    assign w_wrap      = w_at_top && i_run;
    assign w_accept    = i_cfg_we && !w_at_top;
    assign o_cfg_ready = !w_at_top;

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_run) w_state_nxt = ST_RUN;
                else       w_state_nxt = ST_IDLE;
            end
            ST_RUN: begin
                if (!i_run) w_state_nxt = ST_IDLE;
                else        w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Prescaler: counts only while running, cleared when idle or leaving RUN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_presc <= '0;
        end else if ((r_state == ST_RUN) && i_run) begin
            r_presc <= w_at_top ? '0 : r_presc + PRESCALE_W'(1);
        end else begin
            r_presc <= '0;
        end
    end

    // Per-channel period registers, counters and tick generation
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < NCH; i++) begin
                r_period[i] <= '0;
                r_count[i]  <= '0;
            end
            r_ch_tick <= '0;
        end else begin
            r_ch_tick <= '0;
            for (int i = 0; i < NCH; i++) begin
                if (w_accept && (i_cfg_ch == CH_W'(i))) begin
                    r_period[i] <= i_cfg_period;
                    r_count[i]  <= '0;
                end else if ((r_state != ST_RUN) || !i_run) begin
                    r_count[i] <= '0;
                end else if (w_wrap) begin
                    if (!i_ch_en[i] || (r_period[i] == '0)) begin
                        r_count[i] <= '0;
                    end else if (r_count[i] == r_period[i] - PER_W'(1)) begin
                        r_ch_tick[i] <= 1'b1;
                        r_count[i]   <= '0;
                    end else begin
                        r_count[i] <= r_count[i] + PER_W'(1);
                    end
                end
            end
        end
    end

    // Registered status outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_base_tick <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_base_tick <= w_wrap;
            r_busy      <= (w_state_nxt == ST_RUN);
        end
    end

    assign o_base_tick = r_base_tick;
    assign o_busy      = r_busy;
    assign o_ch_tick   = r_ch_tick;

endmodule
